// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI master.
//   SPI_DATA_W - default word length
//   EDGE_W     - width of the SCK edge counter (counts 0..2*SPI_DATA_W)
//   state_t    - master FSM states
//   mode_t     - latched SPI mode {cpol, cpha}
package spi_pkg;

    localparam int SPI_DATA_W = 16;
    localparam int EDGE_W     = 6;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        DONE
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } mode_t;

endpackage

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: SCK divider and edge counter for the SPI master.
//   i_clk    in  system clock
//   i_rst    in  synchronous active-high reset
//   i_run    in  1 while a transfer is in progress (SETUP/XFER/HOLD)
//   i_cpol   in  SCK level to hold while not running
//   o_sck    out serial clock level
//   o_lead   out one-cycle strobe on a leading SCK edge (edge k odd)
//   o_trail  out one-cycle strobe on a trailing SCK edge (edge k even)
//   o_last   out the next edge is the final one (edge 2*DATA_W)
//   o_fin    out divider period after the final edge has elapsed
module spi_sck_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 8,
    parameter int DATA_W  = SPI_DATA_W
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    input  logic i_cpol,
    output logic o_sck,
    output logic o_lead,
    output logic o_trail,
    output logic o_last,
    output logic o_fin
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int NEDGE = 2 * DATA_W;

    logic [DIV_W-1:0]  r_div;
    logic [EDGE_W-1:0] r_edge;
    logic              r_sck;
    logic              w_tick;
    logic              w_active;

    // One tick every CLK_DIV cycles of running; the first lands CLK_DIV
    // cycles after the start, which gives the SETUP delay for free.
    assign w_tick   = i_run && (r_div == DIV_W'(CLK_DIV - 1));
    assign w_active = (r_edge != EDGE_W'(NEDGE));

    assign o_lead  = w_tick && w_active && !r_edge[0];
    assign o_trail = w_tick && w_active &&  r_edge[0];
    assign o_last  = (r_edge == EDGE_W'(NEDGE - 1));
    assign o_fin   = w_tick && !w_active;
    assign o_sck   = r_sck;

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_run) begin
            r_div  <= '0;
            r_edge <= '0;
            r_sck  <= i_cpol;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick && w_active) begin
                r_sck  <= ~r_sck;
                r_edge <= r_edge + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master2.sv
// spi_master2: full-duplex SPI master, one slave, modes 0-3, MSB first.
//   CLK_IN        in  system clock
//   RST           in  synchronous active-high reset
//   EN            in  block enable; low aborts a transfer
//   CPOL, CPHA    in  SPI mode, latched at start
//   StartFlag     in  start request (needs to go low between starts)
//   Master_TxData in  word to send, latched at start
//   MISO          in  serial data from slave
//   SCK, MOSI     out serial clock / data to slave
//   ChipSel       out active-low slave select
//   Master_RxData out last complete received word
//   SPI_Done      out one-cycle pulse when a transfer completes
module spi_master2
    import spi_pkg::*;
#(
    parameter int DATA_W  = SPI_DATA_W,
    parameter int CLK_DIV = 8
) (
    input  logic              CLK_IN,
    input  logic              RST,
    input  logic              EN,
    input  logic              CPOL,
    input  logic              CPHA,
    input  logic              StartFlag,
    input  logic [DATA_W-1:0] Master_TxData,
    input  logic              MISO,
    output logic              SCK,
    output logic              MOSI,
    output logic              ChipSel,
    output logic [DATA_W-1:0] Master_RxData,
    output logic              SPI_Done
);

    state_t            r_state;
    mode_t             r_mode;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_rxdata;
    logic              r_mosi;
    logic              r_cs;
    logic              r_done;
    logic              r_armed;

    logic w_busy, w_run, w_accept;
    logic w_lead, w_trail, w_last, w_fin, w_sck;

    assign w_busy   = (r_state == SETUP) || (r_state == XFER) || (r_state == HOLD);
    assign w_run    = w_busy && EN;
    // r_armed means StartFlag has been seen low since the last accepted
    // start, so a held-high StartFlag yields a single transfer.
    assign w_accept = StartFlag && EN && r_armed &&
                      ((r_state == IDLE) || (r_state == DONE));

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV),
        .DATA_W  (DATA_W)
    ) u_sck_gen (
        .i_clk   (CLK_IN),
        .i_rst   (RST),
        .i_run   (w_run),
        .i_cpol  (w_busy ? r_mode.cpol : CPOL),
        .o_sck   (w_sck),
        .o_lead  (w_lead),
        .o_trail (w_trail),
        .o_last  (w_last),
        .o_fin   (w_fin)
    );

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            r_state  <= IDLE;
            r_mode   <= '0;
            r_tx     <= '0;
            r_rx     <= '0;
            r_rxdata <= '0;
            r_mosi   <= 1'b0;
            r_cs     <= 1'b1;
            r_done   <= 1'b0;
            r_armed  <= 1'b1;
        end else begin
            if (w_accept)
                r_armed <= 1'b0;
            else if (!StartFlag)
                r_armed <= 1'b1;

            if (!EN && w_busy) begin
                // Abort: back to idle outputs, Rx word untouched.
                r_state <= IDLE;
                r_cs    <= 1'b1;
                r_mosi  <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE, DONE: begin
                        r_done <= 1'b0;
                        if (w_accept) begin
                            r_state <= SETUP;
                            r_mode  <= '{cpol: CPOL, cpha: CPHA};
                            r_tx    <= Master_TxData;
                            r_rx    <= '0;
                            r_cs    <= 1'b0;
                            // CPHA=0 needs the MSB valid before the first edge.
                            r_mosi  <= CPHA ? 1'b0 : Master_TxData[DATA_W-1];
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    SETUP, XFER: begin
                        if (w_lead) begin
                            if (r_mode.cpha) begin
                                r_mosi <= r_tx[DATA_W-1];
                                r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
                            end else begin
                                r_rx <= {r_rx[DATA_W-2:0], MISO};
                            end
                            if (r_state == SETUP)
                                r_state <= XFER;
                        end
                        if (w_trail) begin
                            if (r_mode.cpha) begin
                                r_rx <= {r_rx[DATA_W-2:0], MISO};
                            end else if (!w_last) begin
                                // MSB already on MOSI; r_tx[DATA_W-1] is the bit
                                // currently driven, so present the next one.
                                r_mosi <= r_tx[DATA_W-2];
                                r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
                            end
                            if (w_last)
                                r_state <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (w_fin) begin
                            r_state  <= DONE;
                            r_cs     <= 1'b1;
                            r_mosi   <= 1'b0;
                            r_rxdata <= r_rx;
                            r_done   <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign SCK           = w_sck;
    assign MOSI          = r_mosi;
    assign ChipSel       = r_cs;
    assign Master_RxData = r_rxdata;
    assign SPI_Done      = r_done;

endmodule

// File: tb/tb_spi_master2.sv
// tb_spi_master2: directed bench for spi_master2 looped to a behavioural
// SPI slave. Cycle numbers are counted from the clock edge that accepts
// the start (cycle 0); outputs are sampled 1 ns after each rising edge.
module tb_spi_master2;

    logic        CLK_IN = 1'b0;
    logic        RST = 1'b1;
    logic        EN = 1'b1;
    logic        CPOL = 1'b0;
    logic        CPHA = 1'b0;
    logic        StartFlag = 1'b0;
    logic [15:0] Master_TxData = '0;
    logic        MISO = 1'b0;
    logic        SCK, MOSI, ChipSel, SPI_Done;
    logic [15:0] Master_RxData;

    int checks = 0;
    int errors = 0;

    always #5 CLK_IN = ~CLK_IN;

    spi_master2 #(.DATA_W(16), .CLK_DIV(8)) dut (
        .CLK_IN        (CLK_IN),
        .RST           (RST),
        .EN            (EN),
        .CPOL          (CPOL),
        .CPHA          (CPHA),
        .StartFlag     (StartFlag),
        .Master_TxData (Master_TxData),
        .MISO          (MISO),
        .SCK           (SCK),
        .MOSI          (MOSI),
        .ChipSel       (ChipSel),
        .Master_RxData (Master_RxData),
        .SPI_Done      (SPI_Done)
    );

    // Behavioural slave sharing the bench's CPOL/CPHA.
    logic [15:0] s_txword = '0;
    logic [15:0] s_sh = '0;
    logic [15:0] s_rx = '0;
    logic [15:0] s_rxword = '0;
    logic        p_cs = 1'b1;
    logic        p_sck = 1'b0;

    always @(ChipSel or SCK) begin
        if (p_cs && !ChipSel) begin
            s_sh = s_txword;
            s_rx = '0;
            if (!CPHA) MISO = s_sh[15];
        end else if (!ChipSel && (SCK !== p_sck)) begin
            if (SCK != CPOL) begin
                if (!CPHA) s_rx = {s_rx[14:0], MOSI};
                else begin
                    MISO = s_sh[15];
                    s_sh = {s_sh[14:0], 1'b0};
                end
            end else begin
                if (!CPHA) begin
                    s_sh = {s_sh[14:0], 1'b0};
                    MISO = s_sh[15];
                end else s_rx = {s_rx[14:0], MOSI};
            end
        end
        if (!p_cs && ChipSel) s_rxword = s_rx;
        p_cs  = ChipSel;
        p_sck = SCK;
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK_IN);
        #1;
    endtask

    // Leaves time at cycle 0 (just after the accepting edge).
    task automatic start_pulse(input logic [15:0] tx);
        Master_TxData = tx;
        StartFlag = 1'b1;
        step(1);
        StartFlag = 1'b0;
    endtask

    // Runs one transfer and measures it; leaves time at the SPI_Done cycle.
    task automatic run_xfer(input logic [15:0] tx, input logic [15:0] stx,
                            input logic pol, input logic pha,
                            output logic cs0, output int done_cyc,
                            output int cs_high, output int toggles,
                            output int sck_chg, output int mosi_chg);
        logic ps, pm;
        s_txword = stx;
        CPOL = pol;
        CPHA = pha;
        step(2);
        start_pulse(tx);
        cs0 = ChipSel;
        ps = SCK;
        pm = MOSI;
        done_cyc = -1; cs_high = 0; toggles = 0; sck_chg = -1; mosi_chg = -1;
        for (int c = 1; c <= 400; c++) begin
            step(1);
            if (SCK !== ps) begin
                toggles++;
                if (sck_chg < 0) sck_chg = c;
            end
            if (MOSI !== pm && mosi_chg < 0) mosi_chg = c;
            ps = SCK;
            pm = MOSI;
            if (SPI_Done === 1'b1) begin
                done_cyc = c;
                break;
            end
            if (ChipSel !== 1'b0) cs_high++;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; EN = 1'b1; CPOL = 1'b0; CPHA = 1'b0; StartFlag = 1'b0;
        step(3);
        checks++;
        if ({ChipSel, SCK, MOSI, SPI_Done} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_outputs: got cs/sck/mosi/done=%b want 1000", {ChipSel, SCK, MOSI, SPI_Done});
        end
        checks++;
        if (Master_RxData !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rxdata: got %h want 0000", Master_RxData);
        end
        RST = 1'b0;
        step(2);
    endtask

    task automatic test_mode0();
        logic cs0; int dc, csh, tg, sc, mc;
        run_xfer(16'hA9A5, 16'hF0A5, 1'b0, 1'b0, cs0, dc, csh, tg, sc, mc);
        checks++;
        if (dc !== 264) begin errors++; $display("FAIL mode0_done_cycle: got %0d want 264", dc); end
        checks++;
        if (cs0 !== 1'b0 || csh !== 0) begin
            errors++; $display("FAIL mode0_cs_low: cs@0=%b high_cycles=%0d want 0/0", cs0, csh);
        end
        checks++;
        if (Master_RxData !== 16'hF0A5) begin errors++; $display("FAIL mode0_master_rx: got %h want f0a5", Master_RxData); end
        checks++;
        if (s_rxword !== 16'hA9A5) begin errors++; $display("FAIL mode0_slave_rx: got %h want a9a5", s_rxword); end
        checks++;
        if (tg !== 32 || sc !== 8) begin errors++; $display("FAIL mode0_sck: toggles=%0d first=%0d want 32/8", tg, sc); end
        checks++;
        if ({ChipSel, MOSI} !== 2'b10) begin errors++; $display("FAIL mode0_done_pins: got cs/mosi=%b want 10", {ChipSel, MOSI}); end
        step(1);
        checks++;
        if (SPI_Done !== 1'b0) begin errors++; $display("FAIL mode0_done_width: got %b want 0", SPI_Done); end
    endtask

    task automatic test_mode1();
        logic cs0; int dc, csh, tg, sc, mc;
        run_xfer(16'hCCA7, 16'h90B7, 1'b0, 1'b1, cs0, dc, csh, tg, sc, mc);
        checks++;
        if (dc !== 264 || csh !== 0) begin errors++; $display("FAIL mode1_timing: done=%0d cs_high=%0d want 264/0", dc, csh); end
        checks++;
        if (Master_RxData !== 16'h90B7) begin errors++; $display("FAIL mode1_master_rx: got %h want 90b7", Master_RxData); end
        checks++;
        if (s_rxword !== 16'hCCA7) begin errors++; $display("FAIL mode1_slave_rx: got %h want cca7", s_rxword); end
        checks++;
        if (mc !== 8 || sc !== 8) begin errors++; $display("FAIL mode1_first_mosi: mosi_chg=%0d sck_chg=%0d want 8/8", mc, sc); end
    endtask

    task automatic test_mode2();
        logic cs0; int dc, csh, tg, sc, mc;
        CPOL = 1'b1;
        step(2);
        checks++;
        if (SCK !== 1'b1) begin errors++; $display("FAIL mode2_idle_before: got sck=%b want 1", SCK); end
        run_xfer(16'hEFA4, 16'h6C8F, 1'b1, 1'b0, cs0, dc, csh, tg, sc, mc);
        checks++;
        if (dc !== 264 || tg !== 32) begin errors++; $display("FAIL mode2_timing: done=%0d toggles=%0d want 264/32", dc, tg); end
        checks++;
        if (Master_RxData !== 16'h6C8F) begin errors++; $display("FAIL mode2_master_rx: got %h want 6c8f", Master_RxData); end
        checks++;
        if (s_rxword !== 16'hEFA4) begin errors++; $display("FAIL mode2_slave_rx: got %h want efa4", s_rxword); end
        step(1);
        checks++;
        if (SCK !== 1'b1) begin errors++; $display("FAIL mode2_idle_after: got sck=%b want 1", SCK); end
    endtask

    task automatic test_mode3();
        logic cs0; int dc, csh, tg, sc, mc;
        run_xfer(16'hABA2, 16'h5A3C, 1'b1, 1'b1, cs0, dc, csh, tg, sc, mc);
        checks++;
        if (dc !== 264 || tg !== 32) begin errors++; $display("FAIL mode3_timing: done=%0d toggles=%0d want 264/32", dc, tg); end
        checks++;
        if (Master_RxData !== 16'h5A3C) begin errors++; $display("FAIL mode3_master_rx: got %h want 5a3c", Master_RxData); end
        checks++;
        if (s_rxword !== 16'hABA2) begin errors++; $display("FAIL mode3_slave_rx: got %h want aba2", s_rxword); end
        step(2);
    endtask

    task automatic test_abort();
        int dones = 0;
        CPOL = 1'b1; CPHA = 1'b0; s_txword = 16'h1234;
        step(2);
        start_pulse(16'h0F0F);
        step(100);
        EN = 1'b0;
        step(1);
        checks++;
        if ({ChipSel, SCK, MOSI, SPI_Done} !== 4'b1100) begin
            errors++; $display("FAIL abort_pins: got cs/sck/mosi/done=%b want 1100", {ChipSel, SCK, MOSI, SPI_Done});
        end
        for (int c = 0; c < 300; c++) begin
            step(1);
            if (SPI_Done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", dones); end
        checks++;
        if (Master_RxData !== 16'h5A3C) begin errors++; $display("FAIL abort_rx_kept: got %h want 5a3c", Master_RxData); end
        EN = 1'b1;
        step(2);
    endtask

    task automatic test_start_held();
        int dones = 0, falls = 0;
        logic pc;
        CPOL = 1'b0; CPHA = 1'b0; s_txword = 16'h3C3C; Master_TxData = 16'h8001;
        step(2);
        pc = ChipSel;
        StartFlag = 1'b1;
        for (int c = 0; c < 700; c++) begin
            step(1);
            if (SPI_Done === 1'b1) dones++;
            if (pc === 1'b1 && ChipSel === 1'b0) falls++;
            pc = ChipSel;
        end
        StartFlag = 1'b0;
        checks++;
        if (dones !== 1 || falls !== 1) begin
            errors++; $display("FAIL start_held: done=%0d cs_falls=%0d want 1/1", dones, falls);
        end
        checks++;
        if (Master_RxData !== 16'h3C3C || s_rxword !== 16'h8001) begin
            errors++; $display("FAIL start_held_data: m=%h s=%h want 3c3c/8001", Master_RxData, s_rxword);
        end
        step(2);
    endtask

    task automatic test_repulse();
        int dones = 0, dc = -1;
        CPOL = 1'b0; CPHA = 1'b1; s_txword = 16'h7E81;
        step(2);
        start_pulse(16'h4321);
        for (int c = 1; c <= 600; c++) begin
            if (c == 50) begin StartFlag = 1'b1; Master_TxData = 16'hFFFF; end
            if (c == 51) StartFlag = 1'b0;
            step(1);
            if (SPI_Done === 1'b1) begin
                dones++;
                if (dc < 0) dc = c;
            end
        end
        checks++;
        if (dones !== 1 || dc !== 264) begin errors++; $display("FAIL repulse: done=%0d at %0d want 1 at 264", dones, dc); end
        checks++;
        if (Master_RxData !== 16'h7E81 || s_rxword !== 16'h4321) begin
            errors++; $display("FAIL repulse_data: m=%h s=%h want 7e81/4321", Master_RxData, s_rxword);
        end
    endtask

    task automatic test_rst_mid();
        logic cs0; int dc, csh, tg, sc, mc;
        CPOL = 1'b0; CPHA = 1'b1; s_txword = 16'h5555;
        step(2);
        start_pulse(16'hAAAA);
        step(108);
        checks++;
        if ({ChipSel, SCK} !== 2'b01) begin errors++; $display("FAIL rst_mid_pre: got cs/sck=%b want 01", {ChipSel, SCK}); end
        RST = 1'b1;
        step(1);
        checks++;
        if ({ChipSel, SCK, MOSI, SPI_Done} !== 4'b1000 || Master_RxData !== 16'h0000) begin
            errors++; $display("FAIL rst_mid: cs/sck/mosi/done=%b rx=%h want 1000/0000", {ChipSel, SCK, MOSI, SPI_Done}, Master_RxData);
        end
        RST = 1'b0;
        step(2);
        run_xfer(16'h1357, 16'h2468, 1'b0, 1'b0, cs0, dc, csh, tg, sc, mc);
        checks++;
        if (dc !== 264 || Master_RxData !== 16'h2468 || s_rxword !== 16'h1357) begin
            errors++; $display("FAIL rst_recover: done=%0d m=%h s=%h want 264/2468/1357", dc, Master_RxData, s_rxword);
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_mode2();
        test_mode3();
        test_abort();
        test_start_held();
        test_repulse();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
